// File: rtl/rsa_mmio_pkg.sv
// Shared definitions for the RSA CPU data-memory / memory-mapped I/O stage.
// Holds the byte addresses of every I/O register, the region-select enum the
// address decoder produces, the mailbox state enum and the status-word bit
// positions. The decodeRegion helper maps a CPU byte address to a region.
package rsa_mmio_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] OUT_DATA_A = 32'h0001_0000;
  localparam logic [31:0] OUT_STAT_A = 32'h0001_0004;
  localparam logic [31:0] IN_DATA_A  = 32'h0001_0008;
  localparam logic [31:0] IN_STAT_A  = 32'h0001_000C;
  localparam logic [31:0] DONE_A     = 32'h0001_0010;

  // OUT_STAT layout: {count[7:2], full[1], empty[0]}
  localparam int unsigned STAT_EMPTY_BIT   = 0;
  localparam int unsigned STAT_FULL_BIT    = 1;
  localparam int unsigned STAT_COUNT_LSB   = 2;
  localparam int unsigned STAT_COUNT_MSB   = 7;
  localparam int unsigned IN_STAT_FULL_BIT = 0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_OUT_DATA,
    REG_OUT_STAT,
    REG_IN_DATA,
    REG_IN_STAT,
    REG_DONE
  } region_e;

  typedef enum logic {
    MB_EMPTY,
    MB_FULL
  } mbox_state_e;

  // Decode works on the word address only, so addr[1:0] never matter.
  // RAM occupies the first ramWords words of the low 64 KiB.
  function automatic region_e decodeRegion(input logic [31:0] addr,
                                           input int unsigned ramWords);
    region_e r;
    r = REG_NONE;
    if (addr[31:16] == RAM_BASE[31:16] && 32'(addr[15:2]) < ramWords) begin
      r = REG_RAM;
    end else begin
      case (addr[31:2])
        OUT_DATA_A[31:2]: r = REG_OUT_DATA;
        OUT_STAT_A[31:2]: r = REG_OUT_STAT;
        IN_DATA_A[31:2]:  r = REG_IN_DATA;
        IN_STAT_A[31:2]:  r = REG_IN_STAT;
        DONE_A[31:2]:     r = REG_DONE;
        default:          r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/rsa_sync_fifo.sv
// Synchronous single-clock FIFO used as the output stream toward the host.
// Ports: clk_i/rst_ni (async active-low reset), push_i/wdata_i write side,
// pop_i read side, rdata_o head word (0 while empty), full_o/empty_o flags,
// count_o occupancy. A push while full is accepted only if a pop happens in
// the same cycle; otherwise it is ignored (the parent flags the overflow).
module rsa_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             pushOk;
  logic             popOk;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign popOk   = pop_i && !empty_o;
  assign pushOk  = push_i && (!full_o || popOk);

  // Masked while empty so the head port reads 0 after reset and after draining.
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + PW'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({pushOk, popOk})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rsa_mem_io_unit.sv
// Data memory and memory-mapped I/O behind the RSA CPU memory stage.
// Ports: clk, reset (async active-low); CPU side mem_write/addr/write_data
// in, read_data out (1-cycle registered load); out_data/out_valid/out_ready
// output FIFO stream; in_data/in_valid/in_ready operand mailbox; done and ovf
// sticky flags. Loads have no side effects; every side effect is caused by a
// store to the decoded address.
module rsa_mem_io_unit
  import rsa_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        done,
  output logic        ovf
);

  localparam int unsigned AW           = $clog2(RAM_WORDS);
  localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STAT_COUNT_W = STAT_COUNT_MSB - STAT_COUNT_LSB + 1;

  region_e     region;
  logic [AW-1:0] ramIdx;
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ramRd_q;
  logic        selRam_q;
  logic [31:0] mmioRd_d;
  logic [31:0] mmioRd_q;
  logic        done_q;
  logic        ovf_q;
  mbox_state_e mbState_q;
  logic [31:0] mbWord_q;

  logic          fifoPush;
  logic          fifoPop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [CW-1:0] fifoCount;

  assign region   = decodeRegion(addr, RAM_WORDS);
  assign ramIdx   = addr[AW+1:2];
  assign fifoPush = mem_write && (region == REG_OUT_DATA);
  assign fifoPop  = out_valid && out_ready;

  rsa_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_outFifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i (write_data),
    .rdata_o (out_data),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign out_valid = !fifoEmpty;
  assign in_ready  = (mbState_q == MB_EMPTY);
  assign done      = done_q;
  assign ovf       = ovf_q;

  // Load data is split into a RAM path and an I/O path, both registered, so
  // the RAM keeps a plain synchronous-read shape without a reset on its output.
  assign read_data = selRam_q ? ramRd_q : mmioRd_q;

  // Read-before-write: the read samples the array before this edge's store.
  always_ff @(posedge clk) begin
    ramRd_q <= ram[ramIdx];
    if (mem_write && region == REG_RAM) begin
      ram[ramIdx] <= write_data;
    end
  end

  always_comb begin
    mmioRd_d = '0;
    case (region)
      REG_OUT_STAT: begin
        mmioRd_d[STAT_COUNT_MSB:STAT_COUNT_LSB] = STAT_COUNT_W'(fifoCount);
        mmioRd_d[STAT_FULL_BIT]                 = fifoFull;
        mmioRd_d[STAT_EMPTY_BIT]                = fifoEmpty;
      end
      REG_IN_DATA: mmioRd_d = mbWord_q;
      REG_IN_STAT: mmioRd_d[IN_STAT_FULL_BIT] = (mbState_q == MB_FULL);
      REG_DONE:    mmioRd_d[0] = done_q;
      default:     mmioRd_d = '0;
    endcase
  end

  // ovf only fires when the push is truly lost (full and nothing leaving).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      selRam_q <= 1'b0;
      mmioRd_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      selRam_q <= (region == REG_RAM);
      mmioRd_q <= mmioRd_d;
      if (mem_write && region == REG_DONE) done_q <= 1'b1;
      if (fifoPush && fifoFull && !fifoPop) ovf_q <= 1'b1;
    end
  end

  // Clear takes priority: while FULL no offer is accepted, so an offer that
  // coincides with the clear is taken on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mbState_q <= MB_EMPTY;
      mbWord_q  <= '0;
    end else begin
      case (mbState_q)
        MB_EMPTY: begin
          if (in_valid) begin
            mbWord_q  <= in_data;
            mbState_q <= MB_FULL;
          end
        end
        MB_FULL: begin
          if (mem_write && region == REG_IN_STAT) begin
            mbState_q <= MB_EMPTY;
          end
        end
        default: mbState_q <= MB_EMPTY;
      endcase
    end
  end

endmodule
